alu_4bit_serial: RTL and testbench

ALU_4BIT_SERIAL -- requirements
Module: alu_4bit_serial

---
 rtl/alu_4bit_serial.sv | 129 ++++++++++++
 tb/tb_alu_4bit_serial.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_4bit_serial.sv
// Bit-serial 4-bit ALU (AND/OR/ADD/SUB/SLT) built from one 1-bit slice plus a carry flop.
// Latency: start accepted at edge k, result/zero/cout load and done pulses after edge k+4.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted (no gap).
module alu_4bit_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] ALUControl,
  input  logic       start,
  output logic [3:0] result,
  output logic       zero,
  output logic       cout,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt;
  logic [3:0] a_sh, b_sh, sr;
  logic [2:0] op;
  logic       carry;

  logic       accept, last;
  logic       inv_b, b_eff, sum_bit, carry_nxt, slice_bit, less;
  logic [3:0] res_fin;
  logic       cout_fin;

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 2'd3) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-bit datapath slice. SUB/SLT add the inverted B with the carry preset to 1.
  always_comb begin
    inv_b     = (op == OP_SUB) || (op == OP_SLT);
    b_eff     = b_sh[0] ^ inv_b;
    sum_bit   = a_sh[0] ^ b_eff ^ carry;
    carry_nxt = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
    case (op)
      OP_AND:  slice_bit = a_sh[0] & b_sh[0];
      OP_OR:   slice_bit = a_sh[0] | b_sh[0];
      OP_ADD,
      OP_SUB,
      OP_SLT:  slice_bit = sum_bit;
      default: slice_bit = 1'b0;
    endcase
  end

  // Final-bit assembly: on the last step the slice is at bit 3, so carry is the
  // carry into bit 3 and carry_nxt the carry out; their XOR is signed overflow.
  always_comb begin
    less     = sum_bit ^ (carry ^ carry_nxt);
    res_fin  = {slice_bit, sr[3:1]};
    cout_fin = 1'b0;
    if (op == OP_SLT) res_fin = {3'b000, less};
    if ((op == OP_ADD) || (op == OP_SUB)) cout_fin = carry_nxt;
  end

  // Operand capture, serial shifting and registered result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      carry  <= 1'b0;
      a_sh   <= 4'd0;
      b_sh   <= 4'd0;
      sr     <= 4'd0;
      op     <= OP_AND;
      result <= 4'd0;
      zero   <= 1'b1;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= B;
        op    <= ALUControl;
        cnt   <= 2'd0;
        carry <= (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
      end else if (busy) begin
        a_sh  <= {1'b0, a_sh[3:1]};
        b_sh  <= {1'b0, b_sh[3:1]};
        sr    <= {slice_bit, sr[3:1]};
        carry <= carry_nxt;
        cnt   <= cnt + 2'd1;
        if (last) begin
          result <= res_fin;
          zero   <= (res_fin == 4'd0);
          cout   <= cout_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_4bit_serial.sv
// Directed bench for alu_4bit_serial: reset, each opcode, start-while-busy,
// back-to-back and reset-abort scenarios, all with hand-computed expectations.
module tb_alu_4bit_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic [2:0] ALUControl;
  logic       start;
  logic [3:0] result;
  logic       zero, cout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_4bit_serial dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUControl(ALUControl), .start(start),
    .result(result), .zero(zero), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drive one op at the current negedge and wait (bounded) for done.
  // On return we sit at the negedge of the done cycle.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                        output int nbusy, output int ncyc, output bit seen);
    A = a; B = b; ALUControl = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ncyc = 1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) nbusy++;
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic test_vector(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] c, input logic [3:0] er, input logic ez,
                             input logic ec);
    int nb, nc; bit seen;
    run_op(a, b, c, nb, nc, seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL %s_done: done never seen within bound", name); end
    n_tests++;
    if (nb != 4) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected 4", name, nb); end
    n_tests++;
    if (result !== er) begin n_fail++; $display("FAIL %s_result: got %b expected %b", name, result, er); end
    n_tests++;
    if (zero !== ez) begin n_fail++; $display("FAIL %s_zero: got %b expected %b", name, zero, ez); end
    n_tests++;
    if (cout !== ec) begin n_fail++; $display("FAIL %s_cout: got %b expected %b", name, cout, ec); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 4'hF; B = 4'hF; ALUControl = 3'b010;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({result, zero, cout, busy, done} !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b z=%b c=%b busy=%b done=%b expected r=0000 z=1 c=0 busy=0 done=0",
               result, zero, cout, busy, done);
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_priority: busy got %b expected 0", busy); end
  endtask

  task automatic test_add();
    test_vector("add_wrap", 4'b0111, 4'b1001, 3'b010, 4'b0000, 1'b1, 1'b1);
    test_vector("add_small", 4'b0011, 4'b0100, 3'b010, 4'b0111, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    test_vector("sub_neg", 4'b0011, 4'b0101, 3'b110, 4'b1110, 1'b0, 1'b0);
    test_vector("sub_eq", 4'b0101, 4'b0101, 3'b110, 4'b0000, 1'b1, 1'b1);
  endtask

  task automatic test_slt();
    test_vector("slt_true", 4'b1000, 4'b0001, 3'b111, 4'b0001, 1'b0, 1'b0);
    test_vector("slt_false", 4'b0111, 4'b1111, 3'b111, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_logic();
    test_vector("and", 4'b1100, 4'b1010, 3'b000, 4'b1000, 1'b0, 1'b0);
    test_vector("or", 4'b1100, 4'b1010, 3'b001, 4'b1110, 1'b0, 1'b0);
    test_vector("unsup_101", 4'b1100, 4'b1010, 3'b101, 4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int nb; bit seen;
    A = 4'b0001; B = 4'b0010; ALUControl = 3'b010; start = 1'b1;
    @(negedge clk);                       // busy cycle 1
    start = 1'b0;
    @(negedge clk);                       // busy cycle 2: new request must be ignored
    A = 4'b1111; B = 4'b1111; ALUControl = 3'b110; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'b0000; B = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL busy_ignore_done: done never seen within bound"); end
    n_tests++;
    if (result !== 4'b0011 || cout !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_result: got r=%b c=%b expected r=0011 c=0", result, cout);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_no_restart: busy got %b expected 0", busy); end
    nb = 0;
  endtask

  task automatic test_back_to_back();
    int nb, nc; bit seen;
    run_op(4'b0110, 4'b0011, 3'b000, nb, nc, seen);   // AND -> 0010
    n_tests++;
    if (!seen || result !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_first: seen=%0d result=%b expected seen=1 result=0010", seen, result);
    end
    run_op(4'b0110, 4'b0011, 3'b001, nb, nc, seen);   // start in done cycle, OR -> 0111
    n_tests++;
    if (!seen || nc != 5) begin
      n_fail++; $display("FAIL b2b_latency: seen=%0d cycles=%0d expected seen=1 cycles=5", seen, nc);
    end
    n_tests++;
    if (result !== 4'b0111) begin n_fail++; $display("FAIL b2b_second_result: got %b expected 0111", result); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    A = 4'b0011; B = 4'b0100; ALUControl = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);                       // busy cycle 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({busy, result, zero, cout} !== 7'b0_0000_1_0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b r=%b z=%b c=%b expected busy=0 r=0000 z=1 c=0",
                         busy, result, zero, cout);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL abort_no_done: done pulse got 1 expected none"); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0; ALUControl = 3'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_start_while_busy();
    test_back_to_back();
    @(negedge clk);
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
